// File: rtl/vga_write_buffer_pkg.sv
// rtl/vga_write_buffer_pkg.sv - bus address map, status layout and status packing for the VGA write buffer
package vga_write_buffer_pkg;

    localparam logic [31:0] VGA_ADDR      = 32'h0000_8000;
    localparam logic [31:0] VGA_STAT_ADDR = 32'h0000_8004;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    function automatic logic [31:0] pack_status(input logic [7:0] cnt,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] s;
        s = '0;
        s[STAT_CNT_LSB +: 8] = cnt;
        s[STAT_OVF]          = ovf;
        s[STAT_FULL]         = full;
        s[STAT_EMPTY]        = empty;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // flush overrides any same-cycle pop; the write side is left untouched
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vga_write_buffer.sv
// rtl/vga_write_buffer.sv - buffers core pixel writes ahead of vga_memory
// Holds the bus address decode, the sticky overflow flag and the status read mux.
module vga_write_buffer
    import vga_write_buffer_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] DATA_ADDR = VGA_ADDR,
    parameter logic [31:0] STAT_ADDR = VGA_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    output logic [31:0] bus_rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          push, ctrl_we, flush, pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          overflow_q, overflow_d;

    assign push    = bus_we && (bus_addr == DATA_ADDR);
    assign ctrl_we = bus_we && (bus_addr == STAT_ADDR);
    assign flush   = ctrl_we && bus_wdata[CTRL_FLUSH];
    assign pop     = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (bus_wdata),
        .pop   (pop),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !pop)              overflow_d = 1'b1;
        if (ctrl_we && bus_wdata[CTRL_CLR_OVF])     overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    assign bus_rdata = (bus_addr == STAT_ADDR)
                     ? pack_status(8'(fifo_count), overflow_q, fifo_full, fifo_empty)
                     : 32'h0;

endmodule
